// File: rtl/multi_operand_adder_pkg.sv
// Shared types and sizing helpers for the multi-operand accumulating adder.
package multi_operand_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result width large enough that NUM_OPS in-range operands never overflow.
  function automatic int sum_width(input int width, input int num_ops);
    if (num_ops <= 1) return width;
    return width + $clog2(num_ops);
  endfunction

endpackage

// File: rtl/multi_operand_adder_ripple_adder.sv
// Combinational SUM_W-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_adder #(
  parameter int SUM_W = 6
) (
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [SUM_W-1:0] s
);

  logic [SUM_W-1:0] c;

  assign c[0] = 1'b0;

  // The carry out of the top cell is never formed; results are modulo 2^SUM_W.
  for (genvar i = 0; i < SUM_W; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < SUM_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

endmodule

// File: rtl/multi_operand_adder.sv
// Accumulates NUM_OPS handshaked operands and presents their registered sum.
module multi_operand_adder
  import multi_operand_adder_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_OPS = 3,
  parameter  int SIGNED  = 0,
  localparam int SUM_W   = sum_width(WIDTH, NUM_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(NUM_OPS + 1);

  state_t           state, state_nxt;
  logic             armed;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] acc_p1;
  logic [SUM_W-1:0] operand_p0;
  logic [SUM_W-1:0] add_p0;
  logic             accept;
  logic             last_op;

  function automatic logic [SUM_W-1:0] extend(input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] ds;
    ds = d;
    if (SIGNED != 0) return SUM_W'(ds);
    return SUM_W'(d);
  endfunction

  assign operand_p0 = extend(in_data);
  assign accept     = in_valid && in_ready && !clear;
  assign last_op    = (count == CNT_W'(NUM_OPS - 1));

  ripple_adder #(.SUM_W(SUM_W)) u_add (
    .a (acc_p1),
    .b (operand_p0),
    .s (add_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = (NUM_OPS == 1) ? DONE : ACCUM;
      ACCUM: if (accept && last_op) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // armed keeps in_ready low for one cycle after reset release or clear.
  always_comb begin
    in_ready  = armed && (state != DONE);
    out_valid = (state == DONE);
  end

  // Stage p0 -> p1: extended operand is loaded or added into the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      count  <= '0;
      acc_p1 <= '0;
    end else begin
      armed <= !clear;
      if (clear) begin
        count  <= '0;
        acc_p1 <= '0;
      end else if (accept) begin
        if (state == IDLE) begin
          count  <= CNT_W'(1);
          acc_p1 <= operand_p0;
        end else begin
          count  <= count + CNT_W'(1);
          acc_p1 <= add_p0;
        end
      end
    end
  end

  assign sum = acc_p1;

endmodule

// File: tb/tb_multi_operand_adder.sv
// Randomised self-checking bench for multi_operand_adder across several parameter sets.
module tb_multi_operand_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  // Default configuration: WIDTH=4, NUM_OPS=3, unsigned.
  logic       d_clear = 0, d_valid = 0, d_oready = 0;
  logic [3:0] d_in = 0;
  logic       d_ready, d_ovalid;
  logic [5:0] d_sum;

  // Signed configuration: WIDTH=4, NUM_OPS=3.
  logic       s_clear = 0, s_valid = 0, s_oready = 0;
  logic [3:0] s_in = 0;
  logic       s_ready, s_ovalid;
  logic [5:0] s_sum;

  // Parameter sweep instances.
  logic [3:0]  sw_clear = '0, sw_valid = '0, sw_oready = '0;
  logic [7:0]  sw_in [4];
  logic [3:0]  sw_ready, sw_ovalid;
  logic [10:0] sw_sum [4];

  function automatic int cfg_w(input int k);
    return (k == 1 || k == 3) ? 8 : 1;
  endfunction

  function automatic int cfg_n(input int k);
    return (k == 1 || k == 2) ? 5 : 1;
  endfunction

  multi_operand_adder #(.WIDTH(4), .NUM_OPS(3), .SIGNED(0)) u_def (
    .clk(clk), .rst_n(rst_n), .clear(d_clear), .in_data(d_in), .in_valid(d_valid),
    .in_ready(d_ready), .sum(d_sum), .out_valid(d_ovalid), .out_ready(d_oready));

  multi_operand_adder #(.WIDTH(4), .NUM_OPS(3), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_data(s_in), .in_valid(s_valid),
    .in_ready(s_ready), .sum(s_sum), .out_valid(s_ovalid), .out_ready(s_oready));

  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int W  = cfg_w(k);
    localparam int N  = cfg_n(k);
    localparam int SW = W + $clog2(N);
    logic [SW-1:0] s;
    multi_operand_adder #(.WIDTH(W), .NUM_OPS(N), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(sw_clear[k]), .in_data(sw_in[k][W-1:0]),
      .in_valid(sw_valid[k]), .in_ready(sw_ready[k]), .sum(s),
      .out_valid(sw_ovalid[k]), .out_ready(sw_oready[k]));
    assign sw_sum[k] = 11'(s);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_send(input logic [3:0] v);
    d_in = v;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
  endtask

  task automatic d_consume();
    d_oready = 1'b1;
    step();
    d_oready = 1'b0;
  endtask

  task automatic test_reset();
    d_in = 4'hF; d_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (d_sum !== 6'd0) begin miscompares++; $display("FAIL reset_sum: got %0d want 0", d_sum); end
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_ovalid: got %b want 0", d_ovalid); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", d_ready); end
    rst_n = 1'b1;
    #1;
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL release_ready_early: got %b want 0", d_ready); end
    d_valid = 1'b0;
    step();
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", d_ready); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready_sgn: got %b want 1", s_ready); end
    vectors++; if (d_sum !== 6'd0) begin miscompares++; $display("FAIL release_sum: got %0d want 0", d_sum); end
  endtask

  task automatic test_max_operands();
    d_in = 4'd15; d_valid = 1'b1;
    step(); step();
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL max_early_ovalid: got %b want 0", d_ovalid); end
    step();
    d_valid = 1'b0;
    vectors++; if (d_ovalid !== 1'b1) begin miscompares++; $display("FAIL max_ovalid: got %b want 1", d_ovalid); end
    vectors++; if (d_sum !== 6'b101101) begin miscompares++; $display("FAIL max_sum: got %0d want 45", d_sum); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL max_ready_done: got %b want 0", d_ready); end
    d_consume();
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL max_ovalid_after: got %b want 0", d_ovalid); end
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL max_ready_after: got %b want 1", d_ready); end
  endtask

  task automatic test_gaps();
    int total = 0;
    for (int i = 1; i <= 3; i++) begin
      d_send(4'(i));
      total += i;
      if (i < 3) begin
        repeat (2) begin
          d_in = 4'($urandom);
          step();
          vectors++; if (d_sum !== 6'(total)) begin miscompares++; $display("FAIL gap_hold: got %0d want %0d", d_sum, total); end
          vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL gap_ovalid: got %b want 0", d_ovalid); end
        end
      end
    end
    vectors++; if (d_ovalid !== 1'b1) begin miscompares++; $display("FAIL gap_ovalid_end: got %b want 1", d_ovalid); end
    vectors++; if (d_sum !== 6'd6) begin miscompares++; $display("FAIL gap_sum: got %0d want 6", d_sum); end
    d_consume();
  endtask

  task automatic test_back_pressure();
    int total = 0, total2 = 0;
    logic [3:0] v;
    for (int i = 0; i < 3; i++) begin v = 4'($urandom); total += v; d_send(v); end
    for (int c = 0; c < 5; c++) begin
      d_in = 4'($urandom); d_valid = 1'b1; d_oready = 1'b0;
      step();
      vectors++; if (d_sum !== 6'(total)) begin miscompares++; $display("FAIL stall_sum: got %0d want %0d", d_sum, total); end
      vectors++; if (d_ovalid !== 1'b1) begin miscompares++; $display("FAIL stall_ovalid: got %b want 1", d_ovalid); end
      vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", d_ready); end
    end
    d_in = 4'd9; d_valid = 1'b1; d_oready = 1'b1;
    step();
    d_valid = 1'b0; d_oready = 1'b0;
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL handshake_ovalid: got %b want 0", d_ovalid); end
    vectors++; if (d_sum !== 6'(total)) begin miscompares++; $display("FAIL handshake_no_accept: got %0d want %0d", d_sum, total); end
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL handshake_ready: got %b want 1", d_ready); end
    for (int i = 0; i < 3; i++) begin v = 4'($urandom); total2 += v; d_send(v); end
    vectors++; if (d_sum !== 6'(total2)) begin miscompares++; $display("FAIL restart_sum: got %0d want %0d", d_sum, total2); end
    d_consume();
  endtask

  task automatic test_reset_and_clear();
    d_send(4'd9); d_send(4'd9);
    rst_n = 1'b0;
    #1;
    vectors++; if (d_sum !== 6'd0) begin miscompares++; $display("FAIL midreset_sum: got %0d want 0", d_sum); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b want 0", d_ready); end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL midreset_stale: got %b want 0", d_ovalid); end
    d_send(4'd4); d_send(4'd4); d_send(4'd4);
    vectors++; if (d_ovalid !== 1'b1) begin miscompares++; $display("FAIL midreset_ovalid: got %b want 1", d_ovalid); end
    vectors++; if (d_sum !== 6'd12) begin miscompares++; $display("FAIL midreset_result: got %0d want 12", d_sum); end
    d_consume();
    d_send(4'd5);
    d_clear = 1'b1; d_in = 4'd7; d_valid = 1'b1;
    step();
    d_clear = 1'b0; d_valid = 1'b0;
    vectors++; if (d_sum !== 6'd0) begin miscompares++; $display("FAIL clear_sum: got %0d want 0", d_sum); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL clear_ready: got %b want 0", d_ready); end
    step();
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL clear_ready_back: got %b want 1", d_ready); end
    d_send(4'd2); d_send(4'd2); d_send(4'd2);
    vectors++; if (d_sum !== 6'd6) begin miscompares++; $display("FAIL clear_result: got %0d want 6", d_sum); end
    d_clear = 1'b1;
    step();
    d_clear = 1'b0;
    vectors++; if (d_ovalid !== 1'b0) begin miscompares++; $display("FAIL clear_in_done: got %b want 0", d_ovalid); end
    step();
  endtask

  task automatic test_random_unsigned();
    int total;
    logic [3:0] v;
    for (int r = 0; r < 20; r++) begin
      total = 0;
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(0, 2)) begin d_in = 4'($urandom); step(); end
        v = 4'($urandom); total += v; d_send(v);
      end
      vectors++; if (d_sum !== 6'(total)) begin miscompares++; $display("FAIL rand_sum: got %0d want %0d", d_sum, total); end
      repeat ($urandom_range(0, 3)) step();
      d_consume();
    end
  endtask

  task automatic test_signed();
    int total;
    logic signed [3:0] v;
    for (int r = 0; r < 22; r++) begin
      total = 0;
      for (int i = 0; i < 3; i++) begin
        if (r == 0)      v = -4'sd8;
        else if (r == 1) v = (i == 0) ? 4'sd7 : ((i == 1) ? -4'sd1 : -4'sd6);
        else             v = 4'($urandom);
        repeat ($urandom_range(0, 2)) step();
        total += int'(v);
        s_in = v; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
      end
      vectors++; if (s_ovalid !== 1'b1) begin miscompares++; $display("FAIL sgn_ovalid: got %b want 1", s_ovalid); end
      vectors++; if (s_sum !== 6'(total)) begin miscompares++; $display("FAIL sgn_sum: got %0d want %0d", $signed(s_sum), total); end
      repeat ($urandom_range(0, 3)) step();
      s_oready = 1'b1;
      step();
      s_oready = 1'b0;
    end
  endtask

  task automatic test_sweep(input int k);
    int w, n, sw;
    logic [10:0] expv, smask;
    logic [7:0] op;
    w = cfg_w(k); n = cfg_n(k); sw = w + $clog2(n);
    smask = 11'((1 << sw) - 1);
    for (int r = 0; r < 8; r++) begin
      expv = '0;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step();
        vectors++; if (sw_ready[k] !== 1'b1) begin miscompares++; $display("FAIL sweep%0d_ready: got %b want 1", k, sw_ready[k]); end
        op = 8'($urandom) & 8'((1 << w) - 1);
        sw_in[k] = op; sw_valid[k] = 1'b1;
        step();
        sw_valid[k] = 1'b0;
        expv = expv + 11'(op);
      end
      vectors++; if (sw_ovalid[k] !== 1'b1) begin miscompares++; $display("FAIL sweep%0d_ovalid: got %b want 1", k, sw_ovalid[k]); end
      vectors++; if (sw_sum[k] !== (expv & smask)) begin miscompares++; $display("FAIL sweep%0d_sum: got %0d want %0d", k, sw_sum[k], expv & smask); end
      sw_oready[k] = 1'b1;
      step();
      sw_oready[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) sw_in[k] = '0;
    test_reset();
    test_max_operands();
    test_gaps();
    test_back_pressure();
    test_reset_and_clear();
    test_random_unsigned();
    test_signed();
    for (int k = 0; k < 4; k++) test_sweep(k);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_operand_adder.md
MULTI_OPERAND_ADDER -- requirements
Module: multi_operand_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand width in bits (minimum 1).
REQ-002 The block SHALL have parameter NUM_OPS, default 3, meaning the number of operands per sum (minimum 1).
REQ-003 The block SHALL have parameter SIGNED, default 0, meaning 0 for unsigned (zero-extend) and 1 for two's-complement (sign-extend) operands.
REQ-004 The block SHALL define derived constant SUM_W = WIDTH + clog2(NUM_OPS), with SUM_W = WIDTH when NUM_OPS = 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abort of the operation in progress.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-009 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-011 The block SHALL have port sum, output, SUM_W bits: the result.
REQ-012 The block SHALL have port out_valid, output, 1 bit: sum is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes sum.

Function
REQ-014 An operand SHALL be accepted only on a cycle where in_valid and in_ready are both 1; a result SHALL be taken only where out_valid and out_ready are both 1.
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE, and SHALL enter IDLE on reset.
REQ-016 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 In IDLE, an accepted operand SHALL load the accumulator with the extended operand (not added to the old value) and set count to 1.
REQ-018 After the first operand, the FSM SHALL go to ACCUM, or to DONE when NUM_OPS = 1.
REQ-019 In ACCUM, each accepted operand SHALL be extended to SUM_W bits, added to the accumulator, and increment count.
REQ-020 On acceptance of operand number NUM_OPS, the FSM SHALL go to DONE.
REQ-021 Cycles with in_valid = 0 SHALL leave the accumulator, count and state unchanged.
REQ-022 out_valid SHALL assert on the cycle after the last operand is accepted, so latency is 1 cycle.
REQ-023 sum SHALL be a registered output driven straight from the accumulator, and SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-024 In DONE, out_ready = 1 SHALL return the FSM to IDLE; no operand SHALL be accepted that cycle.
REQ-025 Peak throughput SHALL be NUM_OPS + 1 cycles per result.
REQ-026 Arithmetic SHALL be modulo 2^SUM_W; no overflow SHALL be possible for in-range operands, so the block SHALL have no carry or overflow output.
REQ-027 With SIGNED = 1, the result SHALL be the exact two's-complement sum in SUM_W bits.
REQ-028 clear = 1 SHALL force IDLE, count to 0, the accumulator to 0, out_valid to 0 and in_ready to 0 on the next edge, in any state.
REQ-029 Asserting clear SHALL discard any operand presented that cycle, and clear SHALL take priority over all handshakes.

Reset
REQ-030 While rst_n = 0, the block SHALL hold sum = 0, out_valid = 0, in_ready = 0, count = 0 and state = IDLE, applied asynchronously.
REQ-031 Reset deassertion SHALL be synchronised externally; in_ready SHALL become 1 on the first clk edge after rst_n rises.
REQ-032 Reset in the middle of an operation SHALL discard the partial sum, and no stale out_valid SHALL appear after reset.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (IDLE, ACCUM, DONE) and the function computing SUM_W.
REQ-034 One sub-module, ripple_adder, SHALL be instantiated: a parameterised SUM_W-bit combinational ripple-carry adder built from a chain of 1-bit full-adder cells, carry-in tied to 0, carry-out unused.
REQ-035 The count register SHALL be clog2(NUM_OPS + 1) bits wide.

Verification
REQ-036 With default parameters, operands 15, 15, 15 with in_valid held high SHALL give sum = 45 (6'b101101) with out_valid asserted exactly 1 cycle after the third acceptance.
REQ-037 Operands 1, 2, 3 with in_valid low for 2 cycles between each operand SHALL give sum = 6, and the accumulator SHALL be unchanged during the gaps.
REQ-038 With SIGNED = 1 and WIDTH = 4, operands -8, -8, -8 SHALL give sum = -24 (6'b101000); operands 7, -1, -6 SHALL give sum = 0.
REQ-039 With out_ready held low 5 cycles in DONE, sum and out_valid SHALL stay stable and in_ready SHALL stay 0; the next operation SHALL start cleanly after the handshake and SHALL not include the previous sum.
REQ-040 rst_n pulsed low after 2 of 3 operands, then operands 4, 4, 4 presented, SHALL give sum = 12; clear after 1 operand, then 2, 2, 2 presented, SHALL give sum = 6.
REQ-041 Parameter sweep NUM_OPS = 1, 5 and WIDTH = 1, 8, with random operands, SHALL match a reference-model sum on every result.
